// File: rtl/seg_draw_controller.sv
// Seven-segment drawing puzzle sequencer: hit-tests clicks, toggles segments, checks the drawn digit.
// Optional build macro SEG_DRAW_STREAK_EN adds a 3-bit success streak counter shown on led[9:7].
module seg_draw_controller #(
    parameter int HOLD_CYCLES    = 100_000_000,
    parameter int LOCKOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mouse_l,
    input  logic        mouse_r,
    input  logic [6:0]  x_mouse,
    input  logic [5:0]  y_mouse,
    input  logic        confirm,
    input  logic [3:0]  target,
    output logic [6:0]  seg_state,
    output logic [3:0]  digit,
    output logic [1:0]  state,
    output logic [15:0] led
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        EDIT      = 2'd0,
        CHECK     = 2'd1,
        SHOW_OK   = 2'd2,
        SHOW_FAIL = 2'd3
    } state_t;

    state_t              state_r;
    logic [6:0]          seg_state_r;
    logic [3:0]          digit_r;
    logic                mouse_l_q_r;
    logic                mouse_r_q_r;
    logic [LOCK_W-1:0]   lockout_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                l_edge_s;
    logic                r_edge_s;
    logic                hit_s;
    logic [2:0]          hit_idx_s;
    logic                match_s;
    logic [2:0]          streak_s;

    function automatic logic in_box(input logic [6:0] x, input logic [5:0] y,
                                    input logic [6:0] x0, input logic [6:0] x1,
                                    input logic [5:0] y0, input logic [5:0] y1);
        in_box = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

    function automatic logic [3:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0111111: decode_seg = 4'd0;
            7'b0000110: decode_seg = 4'd1;
            7'b1011011: decode_seg = 4'd2;
            7'b1001111: decode_seg = 4'd3;
            7'b1100110: decode_seg = 4'd4;
            7'b1101101: decode_seg = 4'd5;
            7'b1111101: decode_seg = 4'd6;
            7'b0000111: decode_seg = 4'd7;
            7'b1111111: decode_seg = 4'd8;
            7'b1101111: decode_seg = 4'd9;
            default:    decode_seg = 4'hF;
        endcase
    endfunction

    assign l_edge_s = mouse_l & ~mouse_l_q_r;
    assign r_edge_s = mouse_r & ~mouse_r_q_r;
    // An invalid decode (F) must never match, even when target is also F.
    assign match_s  = (digit_r == target) && (digit_r != 4'hF);

    // Hit test: first matching box in index order wins, so shared corners go to the lower index.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 3'd0;
        if (in_box(x_mouse, y_mouse, 7'd9, 7'd29, 6'd4, 6'd6)) begin
            hit_s = 1'b1; hit_idx_s = 3'd0;
        end else if (in_box(x_mouse, y_mouse, 7'd27, 7'd29, 6'd4, 6'd27)) begin
            hit_s = 1'b1; hit_idx_s = 3'd1;
        end else if (in_box(x_mouse, y_mouse, 7'd27, 7'd29, 6'd29, 6'd47)) begin
            hit_s = 1'b1; hit_idx_s = 3'd2;
        end else if (in_box(x_mouse, y_mouse, 7'd9, 7'd29, 6'd45, 6'd47)) begin
            hit_s = 1'b1; hit_idx_s = 3'd3;
        end else if (in_box(x_mouse, y_mouse, 7'd9, 7'd11, 6'd29, 6'd47)) begin
            hit_s = 1'b1; hit_idx_s = 3'd4;
        end else if (in_box(x_mouse, y_mouse, 7'd9, 7'd11, 6'd4, 6'd27)) begin
            hit_s = 1'b1; hit_idx_s = 3'd5;
        end else if (in_box(x_mouse, y_mouse, 7'd9, 7'd29, 6'd26, 6'd28)) begin
            hit_s = 1'b1; hit_idx_s = 3'd6;
        end else begin
            hit_s     = 1'b0;
            hit_idx_s = 3'd0;
        end
    end

    // Main sequencer: button edge history, click lockout, segment editing and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= EDIT;
            seg_state_r   <= 7'd0;
            mouse_l_q_r   <= 1'b0;
            mouse_r_q_r   <= 1'b0;
            lockout_cnt_r <= '0;
            hold_cnt_r    <= '0;
        end else begin
            mouse_l_q_r <= mouse_l;
            mouse_r_q_r <= mouse_r;
            if (lockout_cnt_r != '0) begin
                lockout_cnt_r <= lockout_cnt_r - 1'b1;
            end
            case (state_r)
                EDIT: begin
                    if (confirm) begin
                        state_r <= CHECK;
                    end else if (r_edge_s) begin
                        seg_state_r <= 7'd0;
                    end else if (l_edge_s && (lockout_cnt_r == '0) && hit_s) begin
                        seg_state_r   <= seg_state_r ^ (7'b0000001 << hit_idx_s);
                        lockout_cnt_r <= LOCK_W'(LOCKOUT_CYCLES - 1);
                    end
                end
                CHECK: begin
                    state_r    <= match_s ? SHOW_OK : SHOW_FAIL;
                    hold_cnt_r <= HOLD_W'(HOLD_CYCLES - 1);
                end
                SHOW_OK: begin
                    if (hold_cnt_r == '0) begin
                        state_r     <= EDIT;
                        seg_state_r <= 7'd0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 1'b1;
                    end
                end
                SHOW_FAIL: begin
                    // A failed drawing stays on screen so the user can fix it.
                    if (hold_cnt_r == '0) begin
                        state_r <= EDIT;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= EDIT;
                end
            endcase
        end
    end

    // Registered digit decode, one cycle behind seg_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_r <= 4'hF;
        end else begin
            digit_r <= decode_seg(seg_state_r);
        end
    end

`ifdef SEG_DRAW_STREAK_EN
    logic [2:0] streak_r;

    // Consecutive-success counter, saturating at 7 and cleared by any failure.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_r <= 3'd0;
        end else if (state_r == CHECK) begin
            if (match_s) begin
                streak_r <= (streak_r == 3'd7) ? 3'd7 : streak_r + 3'd1;
            end else begin
                streak_r <= 3'd0;
            end
        end
    end

    assign streak_s = streak_r;
`else
    assign streak_s = 3'd0;
`endif

    assign seg_state = seg_state_r;
    assign digit     = digit_r;
    assign state     = state_r;
    assign led       = {(state_r == SHOW_OK), (state_r == SHOW_FAIL), target, streak_s, seg_state_r};

endmodule

// File: tb/tb_seg_draw_controller.sv
// Directed self-checking bench for seg_draw_controller with short lockout/hold parameters.
module tb_seg_draw_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mouse_l;
    logic        mouse_r;
    logic [6:0]  x_mouse;
    logic [5:0]  y_mouse;
    logic        confirm;
    logic [3:0]  target;
    logic [6:0]  seg_state;
    logic [3:0]  digit;
    logic [1:0]  state;
    logic [15:0] led;

    int n_cmp = 0;
    int n_err = 0;

    seg_draw_controller #(.HOLD_CYCLES(8), .LOCKOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .mouse_l(mouse_l), .mouse_r(mouse_r),
        .x_mouse(x_mouse), .y_mouse(y_mouse), .confirm(confirm), .target(target),
        .seg_state(seg_state), .digit(digit), .state(state), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted-or-not click, then enough idle cycles for the lockout to drain.
    task automatic click(input logic [6:0] x, input logic [5:0] y);
        x_mouse = x;
        y_mouse = y;
        mouse_l = 1'b1;
        tick(1);
        mouse_l = 1'b0;
        tick(4);
    endtask

    initial begin
        reset = 1'b1; mouse_l = 1'b0; mouse_r = 1'b0; x_mouse = 7'd0; y_mouse = 6'd0;
        confirm = 1'b0; target = 4'd0;
        tick(2);
        reset = 1'b0;
        chk("rst_seg", 16'(seg_state), 16'h0000);
        chk("rst_state", 16'(state), 16'h0000);
        chk("rst_digit", 16'(digit), 16'h000F);
        chk("rst_led", led, 16'h0000);

        // Lockout: first click accepted, second 2 cycles later ignored, third after expiry accepted.
        x_mouse = 7'd20; y_mouse = 6'd5; mouse_l = 1'b1;
        tick(1);
        chk("click1", 16'(seg_state), 16'h0001);
        mouse_l = 1'b0; tick(1);
        mouse_l = 1'b1; tick(1);
        chk("click_locked", 16'(seg_state), 16'h0001);
        mouse_l = 1'b0; tick(1);
        mouse_l = 1'b1; tick(1);
        chk("click_after_lock", 16'(seg_state), 16'h0000);
        mouse_l = 1'b0; tick(4);

        click(7'd28, 6'd5);
        chk("corner_seg0", 16'(seg_state), 16'h0001);
        // A miss must not start a lockout: a hit two cycles later is accepted.
        x_mouse = 7'd50; y_mouse = 6'd30; mouse_l = 1'b1; tick(1);
        chk("miss", 16'(seg_state), 16'h0001);
        mouse_l = 1'b0; tick(1);
        x_mouse = 7'd20; y_mouse = 6'd5; mouse_l = 1'b1; tick(1);
        chk("miss_no_lock", 16'(seg_state), 16'h0000);
        mouse_l = 1'b0; tick(4);

        // Draw 1, target 1 -> SHOW_OK for 8 cycles, then cleared.
        click(7'd28, 6'd15);
        click(7'd28, 6'd35);
        chk("draw1_seg", 16'(seg_state), 16'h0006);
        chk("draw1_digit", 16'(digit), 16'h0001);
        target = 4'd1; confirm = 1'b1; tick(1); confirm = 1'b0;
        chk("check_state", 16'(state), 16'h0001);
        tick(1);
        chk("ok_state", 16'(state), 16'h0002);
        chk("ok_led", led, 16'h8406);
        tick(7);
        chk("ok_last", 16'(state), 16'h0002);
        tick(1);
        chk("ok_exit_state", 16'(state), 16'h0000);
        chk("ok_exit_seg", 16'(seg_state), 16'h0000);
`ifdef SEG_DRAW_STREAK_EN
        chk("streak1", 16'(led[9:7]), 16'h0001);
`endif

        // Draw 2, target 3 -> SHOW_FAIL, drawing kept.
        click(7'd20, 6'd5);
        click(7'd28, 6'd15);
        click(7'd20, 6'd46);
        click(7'd10, 6'd35);
        click(7'd20, 6'd27);
        chk("draw2_seg", 16'(seg_state), 16'h005B);
        chk("draw2_digit", 16'(digit), 16'h0002);
        target = 4'd3; confirm = 1'b1; tick(1); confirm = 1'b0;
        tick(1);
        chk("fail_state", 16'(state), 16'h0003);
        chk("fail_led", led, 16'h4C5B);
        tick(8);
        chk("fail_exit_state", 16'(state), 16'h0000);
        chk("fail_exit_seg", 16'(seg_state), 16'h005B);
`ifdef SEG_DRAW_STREAK_EN
        chk("streak0", 16'(led[9:7]), 16'h0000);
`endif

        // Fill to 8, then simultaneous left+right edges clear everything.
        click(7'd28, 6'd35);
        click(7'd10, 6'd15);
        chk("draw8_seg", 16'(seg_state), 16'h007F);
        chk("draw8_digit", 16'(digit), 16'h0008);
        x_mouse = 7'd20; y_mouse = 6'd5; mouse_l = 1'b1; mouse_r = 1'b1; tick(1);
        chk("lr_clear", 16'(seg_state), 16'h0000);
        mouse_l = 1'b0; mouse_r = 1'b0; tick(2);
        chk("blank_digit", 16'(digit), 16'h000F);
        target = 4'd0; confirm = 1'b1; tick(1); confirm = 1'b0;
        tick(1);
        chk("blank_fail", 16'(state), 16'h0003);
        tick(8);
        chk("blank_exit", 16'(state), 16'h0000);

        // Reset mid-hold in SHOW_OK at hold count 3.
        click(7'd28, 6'd15);
        click(7'd28, 6'd35);
        target = 4'd1; confirm = 1'b1; tick(1); confirm = 1'b0;
        tick(1);
        tick(4);
        chk("pre_rst_state", 16'(state), 16'h0002);
        reset = 1'b1; target = 4'd0; tick(1);
        chk("mid_rst_state", 16'(state), 16'h0000);
        chk("mid_rst_seg", 16'(seg_state), 16'h0000);
        chk("mid_rst_led", led, 16'h0000);
        chk("mid_rst_digit", 16'(digit), 16'h000F);
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
